// File: rtl/fp_ratio_sequencer.sv
// Sequences the external MULT and DIV cores to form num / (TWO_PI * x), holding operands
// stable for the whole pass and capturing the quotient with status flags behind a start/done handshake.
module fp_ratio_sequencer #(
  parameter int          MULT_LATENCY = 5,
  parameter int          DIV_LATENCY  = 24,
  parameter logic [63:0] TWO_PI       = 64'h401921FB54442D18
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        start,
  input  logic        clear,
  input  logic [63:0] op_x,
  input  logic [63:0] op_num,
  output logic [63:0] mul_a,
  output logic [63:0] mul_b,
  input  logic [63:0] mul_q,
  output logic [63:0] div_a,
  output logic [63:0] div_b,
  input  logic [63:0] div_q,
  output logic        busy,
  output logic        done,
  output logic        result_valid,
  output logic [63:0] result,
  output logic [3:0]  flags
);

  localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] x_q, x_d, num_q, num_d, prod_q, prod_d, result_q, result_d;
  logic        valid_q, valid_d, overrun_q, overrun_d;
  logic        zdiv_pend_q, zdiv_pend_d, zero_div_q, zero_div_d;
  logic        inf_q, inf_d, nan_q, nan_d;
  logic        accept, clear_ok, q_exp_max, q_man_zero;

  // NOTE: every state register uses <= so all flops update together from pre-edge values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      num_q       <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      zdiv_pend_q <= 1'b0;
      zero_div_q  <= 1'b0;
      inf_q       <= 1'b0;
      nan_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      num_q       <= num_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      zdiv_pend_q <= zdiv_pend_d;
      zero_div_q  <= zero_div_d;
      inf_q       <= inf_d;
      nan_q       <= nan_d;
    end
  end

  assign accept     = start && (state_q == IDLE || state_q == DONE);
  // A clear landing in the done cycle loses to the freshly published result.
  assign clear_ok   = clear && (state_q != DONE);
  assign q_exp_max  = (div_q[62:52] == 11'h7FF);
  assign q_man_zero = (div_q[51:0] == 52'd0);

  // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    num_d       = num_q;
    prod_d      = prod_q;
    result_d    = result_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    zdiv_pend_d = zdiv_pend_q;
    zero_div_d  = zero_div_q;
    inf_d       = inf_q;
    nan_d       = nan_q;

    if (clear_ok) begin
      valid_d    = 1'b0;
      overrun_d  = 1'b0;
      zero_div_d = 1'b0;
      inf_d      = 1'b0;
      nan_d      = 1'b0;
    end

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          x_d     = op_x;
          num_d   = op_num;
          cnt_d   = MUL_LOAD;
          state_d = MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        if (start) overrun_d = 1'b1;
        if (cnt_q == '0) begin
          prod_d      = mul_q;
          zdiv_pend_d = (mul_q[62:0] == 63'd0);
          cnt_d       = DIV_LOAD;
          state_d     = DIV_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV_WAIT: begin
        if (start) overrun_d = 1'b1;
        if (cnt_q == '0) begin
          result_d   = div_q;
          valid_d    = 1'b1;
          zero_div_d = zdiv_pend_q;
          inf_d      = q_exp_max && q_man_zero;
          nan_d      = q_exp_max && !q_man_zero;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mul_a        = TWO_PI;
  assign mul_b        = x_q;
  assign div_a        = num_q;
  assign div_b        = prod_q;
  assign busy         = (state_q == MUL_WAIT) || (state_q == DIV_WAIT);
  assign done         = (state_q == DONE);
  assign result_valid = valid_q;
  assign result       = result_q;
  assign flags        = {overrun_q, zero_div_q, inf_q, nan_q};

endmodule

// File: tb/tb_fp_ratio_sequencer.sv
// Self-checking bench for fp_ratio_sequencer with behavioural fixed-latency MULT/DIV core models
// and a scoreboard of expected {result, flags, done cycle} entries.
module tb_fp_ratio_sequencer;

  localparam int          ML      = 5;
  localparam int          DL      = 24;
  localparam logic [63:0] TWO_PI  = 64'h401921FB54442D18;
  localparam logic [63:0] ONE     = 64'h3FF0000000000000;
  localparam logic [63:0] INV_2PI = 64'h3FC45F306DC9C883;
  localparam logic [63:0] POS_INF = 64'h7FF0000000000000;
  localparam logic [63:0] NEG_INF = 64'hFFF0000000000000;
  localparam logic [63:0] QNAN    = 64'h7FF8000000000000;

  logic        clk = 1'b0;
  logic        areset, start, clear;
  logic [63:0] op_x, op_num, mul_a, mul_b, mul_q, div_a, div_b, div_q, result;
  logic        busy, done, result_valid;
  logic [3:0]  flags;

  fp_ratio_sequencer #(.MULT_LATENCY(ML), .DIV_LATENCY(DL), .TWO_PI(TWO_PI)) dut (
    .clk(clk), .areset(areset), .start(start), .clear(clear),
    .op_x(op_x), .op_num(op_num),
    .mul_a(mul_a), .mul_b(mul_b), .mul_q(mul_q),
    .div_a(div_a), .div_b(div_b), .div_q(div_q),
    .busy(busy), .done(done), .result_valid(result_valid),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] fdiv(input logic [63:0] a, input logic [63:0] b);
    if (b[62:0] == 63'd0) begin
      if (a[62:0] == 63'd0 || (a[62:52] == 11'h7FF && a[51:0] != 52'd0)) return QNAN;
      return {a[63] ^ b[63], 11'h7FF, 52'd0};
    end
    return $realtobits($bitstoreal(a) / $bitstoreal(b));
  endfunction

  // Core models: output reflects inputs that were stable for the full pass by the capture edge.
  logic [63:0] mpipe [ML-1];
  logic [63:0] dpipe [DL-1];
  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < ML - 1; i++) mpipe[i] <= mpipe[i-1];
    dpipe[0] <= fdiv(div_a, div_b);
    for (int i = 1; i < DL - 1; i++) dpipe[i] <= dpipe[i-1];
  end
  assign mul_q = mpipe[ML-2];
  assign div_q = dpipe[DL-2];

  typedef struct {
    logic [63:0] res;
    logic [3:0]  flg;
    int          at;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [63:0] x;
    logic [63:0] num;
    logic [63:0] res;
    logic [3:0]  flg;
  } vec_t;
  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!areset && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.at));
        check("result", result, e.res);
        check("flags", {60'd0, flags}, {60'd0, e.flg});
        check("result_valid_on_done", {63'd0, result_valid}, 64'd1);
      end
    end
  end

  task automatic drive_start(input logic [63:0] x, input logic [63:0] num, input bit push,
                             input logic [63:0] res, input logic [3:0] flg);
    exp_t e;
    @(negedge clk); #1;
    op_x = x; op_num = num; start = 1'b1;
    if (push) begin
      e.res = res; e.flg = flg; e.at = cyc + 1 + ML + DL;
      sb.push_back(e);
    end
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (3) @(negedge clk);
    #1 areset = 1'b0;
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; clear = 1'b0; op_x = '0; op_num = '0;
    vecs[0] = '{ONE, ONE, INV_2PI, 4'b0000};
    vecs[1] = '{64'd0, ONE, POS_INF, 4'b0110};
    vecs[2] = '{64'd0, 64'd0, QNAN, 4'b0101};
    vecs[3] = '{64'h4000000000000000, 64'hC008000000000000,
                $realtobits(-3.0 / (2.0 * $bitstoreal(TWO_PI))), 4'b0000};
    vecs[4] = '{$realtobits(1.0e-300), $realtobits(1.0e300), POS_INF, 4'b0010};
    vecs[5] = '{64'h8000000000000000, 64'h4014000000000000, NEG_INF, 4'b0110};

    // Reset state after 10 idle cycles.
    do_reset();
    repeat (10) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, result_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_flags", {60'd0, flags}, 64'd0);
    check("rst_mul_a", mul_a, TWO_PI);
    check("rst_mul_b", mul_b, 64'd0);
    check("rst_div_b", div_b, 64'd0);

    // Table-driven passes through the scoreboard.
    foreach (vecs[i]) begin
      drive_start(vecs[i].x, vecs[i].num, 1'b1, vecs[i].res, vecs[i].flg);
      check("busy_after_start", {63'd0, busy}, 64'd1);
      check("mul_b_latched", mul_b, vecs[i].x);
      check("div_a_latched", div_a, vecs[i].num);
      wait_drain("vec_done_timeout");
    end

    // Start while busy is ignored and flagged as overrun; then clear.
    drive_start(ONE, ONE, 1'b1, INV_2PI, 4'b1000);
    repeat (8) @(negedge clk);
    drive_start(64'h4000000000000000, 64'h401C000000000000, 1'b0, '0, '0);
    check("ovr_mul_b_held", mul_b, ONE);
    check("ovr_div_a_held", div_a, ONE);
    wait_drain("ovr_done_timeout");
    @(negedge clk); #1 clear = 1'b1;
    @(negedge clk); #1 clear = 1'b0;
    check("clr_valid", {63'd0, result_valid}, 64'd0);
    check("clr_flags", {60'd0, flags}, 64'd0);
    check("clr_result_held", result, INV_2PI);

    // Reset in the middle of a pass aborts it with no done.
    drive_start(ONE, ONE, 1'b0, '0, '0);
    repeat (14) @(negedge clk);
    #1;
    do_reset();
    sb.delete();
    repeat (40) @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_valid", {63'd0, result_valid}, 64'd0);
    check("abort_mul_b", mul_b, 64'd0);
    drive_start(ONE, ONE, 1'b1, INV_2PI, 4'b0000);
    wait_drain("post_abort_timeout");

    // clear coincident with done, and a start accepted in the done cycle.
    drive_start(64'd0, ONE, 1'b1, POS_INF, 4'b0110);
    begin
      int n = 0;
      while (!done && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("done_seen", {63'd0, done}, 64'd1);
    end
    begin
      exp_t e;
      #1;
      clear = 1'b1; start = 1'b1; op_x = ONE; op_num = ONE;
      e.res = INV_2PI; e.flg = 4'b0000; e.at = cyc + 1 + ML + DL;
      sb.push_back(e);
    end
    @(negedge clk);
    check("clr_vs_done_valid", {63'd0, result_valid}, 64'd1);
    check("clr_vs_done_flags", {60'd0, flags}, 64'h6);
    check("start_in_done_busy", {63'd0, busy}, 64'd1);
    #1 clear = 1'b0; start = 1'b0;
    wait_drain("b2b_done_timeout");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_ratio_sequencer.md
Name: fp_ratio_sequencer

Overview:
- Drives the double-precision MULT and DIV cores with operands held stable for a full pass, times their fixed pipeline latencies, and captures the final quotient into a result register with status flags.
- Computation: result = num / (TWO_PI * x).
- Sits between the bus-side operand registers and the bus-side results registers, all in the inner-clock domain.
- Replaces free-running, uncaptured core outputs with a start/done handshake.

Parameters:
- MULT_LATENCY, 5: MULT core pipeline depth in clk cycles (>=1).
- DIV_LATENCY, 24: DIV core pipeline depth in clk cycles (>=1).
- TWO_PI, 64'h401921FB54442D18: constant multiplicand fed to MULT.

Ports:
- clk  in  1  inner PLL clock; also clocks the MULT and DIV cores.
- areset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; op_x and op_num are sampled on the same edge.
- clear  in  1  clears result_valid and the sticky flags.
- op_x  in  64  IEEE754 double x.
- op_num  in  64  IEEE754 double numerator.
- mul_a  out  64  to MULT a; always TWO_PI.
- mul_b  out  64  to MULT b; latched x.
- mul_q  in  64  from MULT q.
- div_a  out  64  to DIV a; latched numerator.
- div_b  out  64  to DIV b; latched product.
- div_q  in  64  from DIV q.
- busy  out  1  high from the cycle after an accepted start until the done cycle.
- done  out  1  one-cycle pulse when result is updated.
- result_valid  out  1  sticky; set on done, cleared by clear.
- result  out  64  captured quotient.
- flags  out  4  {overrun, zero_div, inf, nan}.

Behaviour:
- Interface: one clock, clk; reset areset, asynchronous, active-high. Port names match the codebase FP core interface.
- Reset values:
  - busy=0, done=0, result_valid=0, result=0, flags=0.
  - Operand and product registers = 0; state = IDLE; counter = 0.
  - mul_a = TWO_PI at all times.
- Reset mid-operation: aborts immediately. Values still in flight in the cores are ignored; no done follows.
- FSM states: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE:
  - start=1 latches op_x to x_reg and op_num to num_reg.
  - Counter loads MULT_LATENCY-1; next state MUL_WAIT; busy=1.
- MUL_WAIT:
  - Counter decrements each cycle.
  - At counter=0: capture mul_q into prod_reg; evaluate zero_div; load counter DIV_LATENCY-1; go to DIV_WAIT.
- DIV_WAIT:
  - Counter decrements each cycle.
  - At counter=0: capture div_q into result; evaluate nan/inf on div_q; go to DONE.
- DONE:
  - done=1 and result_valid=1 for exactly one cycle; busy=0.
  - Next state IDLE.
  - A start presented in DONE is accepted as if in IDLE.
- Latency:
  - Start sampled at edge E0; product captured at edge E0+MULT_LATENCY; result captured at edge E0+MULT_LATENCY+DIV_LATENCY.
  - done is high during the cycle after that edge; 29 cycles at defaults.
  - Back-to-back throughput: one result per MULT_LATENCY+DIV_LATENCY+1 cycles.
- Operand stability: mul_b, div_a and div_b come only from registers. They change only on an accepted start (mul_b, div_a) or on product capture (div_b).
- Flag rules (IEEE754 binary64: exp=bits[62:52], man=bits[51:0]):
  - nan: result exp=0x7FF and man!=0.
  - inf: result exp=0x7FF and man=0.
  - zero_div: captured product exp=0 and man=0, either sign. This is a status flag only; the quotient is still captured.
  - nan, inf and zero_div are replaced on each done and held until clear or the next done.
- Start while busy (MUL_WAIT/DIV_WAIT): ignored; operands are not relatched. Sets sticky overrun.
- clear and done in the same cycle: done wins; result_valid=1 and the new flags are kept. clear in the same cycle as start: both take effect.
- No arithmetic is performed locally; all 64-bit paths pass through untouched.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, busy=0, mul_a=0x401921FB54442D18.
- op_x=op_num=0x3FF0000000000000, start pulse; bench drives behavioural fixed-latency core models -> busy for 29 cycles, done on cycle 29, result=0x3FC45F306DC9C883 (1/2π), flags=0.
- op_x=0x0000000000000000, op_num=0x3FF0000000000000 -> zero_div=1, inf=1 (div model returns 0x7FF0000000000000), result_valid=1.
- Second start 10 cycles after the first -> ignored, overrun=1, result equals the first computation. Then pulse clear -> result_valid=0, flags=0.
- areset asserted at cycle 15 of a pass, released, then idle 40 cycles -> no done, result=0, busy=0. A new start then completes normally in 29 cycles.
- clear coincident with done -> result_valid=1. Start in the DONE cycle -> accepted; next done occurs exactly 29 cycles later.
